// File: rtl/tv656_decim_decoder.sv
// ITU-R 656 word-stream decoder with 1-in-SKIP_N horizontal pixel decimation.
// Emits {Y, C} per kept pixel together with line/field position and timing-reference status.
module tv656_decim_decoder #(
    parameter int DATA_W = 8,
    parameter int SKIP_N = 9,
    parameter int MAX_X  = 720,
    parameter int Y_W    = 10
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [DATA_W-1:0]     iTD_DATA,
    output logic [2*DATA_W-1:0]   oYCbCr,
    output logic                  oDVAL,
    output logic [9:0]            oTV_X,
    output logic [Y_W-1:0]        oTV_Y,
    output logic                  oFIELD,
    output logic                  oVBLANK,
    output logic                  oSOF,
    output logic                  oERR
);

    localparam int P_W = $clog2(MAX_X + 1);

    typedef enum logic [1:0] {HUNT, BLANK, ACTIVE} state_t;

    state_t            state;
    logic [DATA_W-1:0] d_p0, d_p1, d_p2;
    logic              vld_p0, vld_p1, vld_p2;
    logic [1:0]        ph;
    logic [3:0]        mc;
    logic [P_W-1:0]    pin;
    logic [9:0]        xo;
    logic [DATA_W-1:0] cb_r, cr_r, y0_r;
    logic              pend_vld;
    logic [DATA_W-1:0] pend_y, pend_c;
    logic [9:0]        pend_x;

    logic              preamble, trs, bad_xy, f_bit, v_bit, h_bit, take;
    logic              keep0, keep1, max_hit;
    logic [3:0]        mc1, mc2;
    logic [9:0]        x1;
    logic [P_W-1:0]    pin_inc;

    // Modulo-SKIP_N step done by compare-and-wrap rather than division.
    function automatic logic [3:0] mod_next(input logic [3:0] m);
        if (SKIP_N == 0 || m == 4'(SKIP_N - 1))
            mod_next = 4'd0;
        else
            mod_next = m + 4'd1;
    endfunction

    function automatic logic is_drop(input logic [3:0] m);
        is_drop = (SKIP_N != 0) && (m == 4'(SKIP_N - 1));
    endfunction

    function automatic logic [Y_W-1:0] sat_inc(input logic [Y_W-1:0] v);
        sat_inc = (v == '1) ? v : v + Y_W'(1);
    endfunction

    assign preamble = (d_p2 == '1) && (d_p1 == '0) && (d_p0 == '0);
    assign trs      = preamble && iTD_DATA[DATA_W-1];
    assign bad_xy   = preamble && !iTD_DATA[DATA_W-1];
    assign f_bit    = iTD_DATA[DATA_W-2];
    assign v_bit    = iTD_DATA[DATA_W-3];
    assign h_bit    = iTD_DATA[DATA_W-4];
    // The header's FF word sits in d_p2 on the detect edge, so it is never taken as a pixel.
    assign take     = (state == ACTIVE) && vld_p2 && !trs;
    assign mc1      = mod_next(mc);
    assign mc2      = mod_next(mc1);
    assign keep0    = !is_drop(mc);
    assign keep1    = !is_drop(mc1);
    assign x1       = xo + 10'(keep0);
    assign pin_inc  = pin + P_W'(1);
    assign max_hit  = (pin_inc == P_W'(MAX_X));

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state    <= HUNT;
            d_p0     <= '0;
            d_p1     <= '0;
            d_p2     <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            ph       <= '0;
            mc       <= '0;
            pin      <= '0;
            xo       <= '0;
            cb_r     <= '0;
            cr_r     <= '0;
            y0_r     <= '0;
            pend_vld <= 1'b0;
            pend_y   <= '0;
            pend_c   <= '0;
            pend_x   <= '0;
            oYCbCr   <= '0;
            oDVAL    <= 1'b0;
            oTV_X    <= '0;
            oTV_Y    <= '0;
            oFIELD   <= 1'b0;
            oVBLANK  <= 1'b0;
            oSOF     <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            // p0..p2: word delay line with per-word pixel marks
            d_p0   <= iTD_DATA;
            d_p1   <= d_p0;
            d_p2   <= d_p1;
            vld_p0 <= (state == ACTIVE) && !trs;
            vld_p1 <= vld_p0 && !trs;
            vld_p2 <= vld_p1 && !trs;

            oERR     <= bad_xy || (trs && !h_bit && state == ACTIVE);
            oSOF     <= 1'b0;
            oDVAL    <= 1'b0;
            pend_vld <= 1'b0;

            // Y1 of a completed pair leaves one cycle after its Y0, whatever the state.
            if (pend_vld) begin
                oDVAL  <= 1'b1;
                oYCbCr <= {pend_y, pend_c};
                oTV_X  <= pend_x;
            end

            if (trs) begin
                oVBLANK <= v_bit;
                if (f_bit != oFIELD) begin
                    oFIELD <= f_bit;
                    oSOF   <= 1'b1;
                    oTV_Y  <= '0;
                end else if (h_bit) begin
                    oTV_Y <= sat_inc(oTV_Y);
                end

                if (h_bit) begin
                    state <= BLANK;
                end else if (state != HUNT) begin
                    state <= v_bit ? BLANK : ACTIVE;
                    ph    <= '0;
                    mc    <= '0;
                    pin   <= '0;
                    xo    <= '0;
                end
            end else if (take) begin
                // p3: pair assembly Cb, Y0, Cr, Y1
                ph <= ph + 2'd1;
                case (ph)
                    2'd0: cb_r <= d_p2;
                    2'd1: begin
                        y0_r <= d_p2;
                        pin  <= pin_inc;
                        if (max_hit)
                            state <= BLANK;
                    end
                    2'd2: cr_r <= d_p2;
                    default: begin
                        pin <= pin_inc;
                        if (max_hit)
                            state <= BLANK;
                        if (keep0) begin
                            oDVAL  <= 1'b1;
                            oYCbCr <= {y0_r, xo[0] ? cr_r : cb_r};
                            oTV_X  <= xo;
                        end
                        pend_vld <= keep1;
                        pend_y   <= d_p2;
                        pend_c   <= x1[0] ? cr_r : cb_r;
                        pend_x   <= x1;
                        xo       <= x1 + 10'(keep1);
                        mc       <= mc2;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tv656_decim_decoder.sv
// Directed bench for tv656_decim_decoder: two instances (default, and MAX_X=16 / Y_W=3)
// share one word stream; a per-pixel scoreboard holds hand-derived expected {x, Y, C}.
module tb_tv656_decim_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  td;

    logic [15:0] ycc1, ycc2;
    logic        dval1, dval2;
    logic [9:0]  x1, x2;
    logic [9:0]  y1;
    logic [2:0]  y2;
    logic        fld1, fld2, vb1, vb2, sof1, sof2, err1, err2;

    always #5 clk = ~clk;

    tv656_decim_decoder #(.DATA_W(8), .SKIP_N(9), .MAX_X(720), .Y_W(10)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iTD_DATA(td),
        .oYCbCr(ycc1), .oDVAL(dval1), .oTV_X(x1), .oTV_Y(y1),
        .oFIELD(fld1), .oVBLANK(vb1), .oSOF(sof1), .oERR(err1)
    );

    tv656_decim_decoder #(.DATA_W(8), .SKIP_N(9), .MAX_X(16), .Y_W(3)) dut_small (
        .iCLK(clk), .iRST_N(rst_n), .iTD_DATA(td),
        .oYCbCr(ycc2), .oDVAL(dval2), .oTV_X(x2), .oTV_Y(y2),
        .oFIELD(fld2), .oVBLANK(vb2), .oSOF(sof2), .oERR(err2)
    );

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [25:0] exp_q [0:4095];
    int          exp_n  = 0;
    bit          chk_en = 1'b0;
    int          mp = 0;
    int          mx = 0;

    int          rd = 0, pix_bad = 0, extra = 0;
    int          dv1 = 0, dv2 = 0, nerr = 0, nsof = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dval1) begin
            dv1 <= dv1 + 1;
            if (chk_en) begin
                if (rd < exp_n) begin
                    if ({x1, ycc1} !== exp_q[rd[11:0]])
                        pix_bad <= pix_bad + 1;
                    rd <= rd + 1;
                end else begin
                    extra <= extra + 1;
                end
            end
        end
        if (dval2) dv2  <= dv2 + 1;
        if (err1)  nerr <= nerr + 1;
        if (sof1)  nsof <= nsof + 1;
    end

    function automatic logic [7:0] ypix(input int p);
        ypix = 8'h20 + 8'(p % 128);
    endfunction

    task automatic put(input logic [7:0] w);
        td = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(8'h10);
    endtask

    task automatic trs(input bit f, input bit v, input bit h);
        put(8'hFF); put(8'h00); put(8'h00);
        put({1'b1, f, v, h, 4'b0000});
    endtask

    task automatic sav(input bit f, input bit v);
        trs(f, v, 1'b0);
        mp = 0;
        mx = 0;
    endtask

    task automatic pairs(input int n, input bit push);
        logic [7:0] cb, cr;
        int         p;
        for (int i = 0; i < n; i++) begin
            cb = 8'(8'h10 + mp);
            cr = 8'(8'h80 + mp);
            put(cb); put(ypix(2 * mp)); put(cr); put(ypix(2 * mp + 1));
            if (push) begin
                for (int j = 0; j < 2; j++) begin
                    p = 2 * mp + j;
                    if (p % 9 != 8) begin
                        exp_q[exp_n[11:0]] = {10'(mx), ypix(p), (mx % 2 == 0) ? cb : cr};
                        exp_n++;
                        mx++;
                    end
                end
            end
            mp++;
        end
    endtask

    task automatic sb_check(input string tag);
        check_eq({tag, "_pix"}, 32'(pix_bad), 32'd0);
        check_eq({tag, "_extra"}, 32'(extra), 32'd0);
        check_eq({tag, "_cnt"}, 32'(rd), 32'(exp_n));
    endtask

    int s1, s2, se, ss;

    initial begin
        td    = 8'h10;
        rst_n = 1'b0;
        idle(3);
        check_eq("rst_out", 32'({dval1, x1, y1, ycc1, fld1, vb1, sof1, err1}), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Bad XY in HUNT: error pulse only, then SAV must not activate from HUNT.
        se = nerr; ss = nsof;
        put(8'hFF); put(8'h00); put(8'h00); put(8'h70);
        idle(3);
        check_eq("hunt_bad_err", 32'(nerr - se), 32'd1);
        check_eq("hunt_bad_fld", 32'({fld1, vb1}), 32'd0);
        check_eq("hunt_bad_sof", 32'(nsof - ss), 32'd0);
        sav(0, 0); pairs(3, 0); trs(0, 0, 1);
        idle(6);
        sb_check("hunt");

        // First-pair latency: Y0 after 5 cycles, Y1 after 4.
        chk_en = 1'b0;
        sav(0, 0);
        put(8'h10); put(8'h20); put(8'h80); put(8'h21);
        put(8'h11); put(8'h22);
        check_eq("lat_early", 32'(dval1), 32'd0);
        put(8'h81);
        check_eq("lat_y0", 32'({dval1, x1, ycc1}), 32'({1'b1, 10'd0, 8'h20, 8'h10}));
        put(8'h23);
        check_eq("lat_y1", 32'({dval1, x1, ycc1}), 32'({1'b1, 10'd1, 8'h21, 8'h80}));
        trs(0, 0, 1);
        idle(8);
        chk_en = 1'b1;

        // Full 720-pixel line, SKIP_N=9: 640 kept; small instance caps at 16 inputs -> 15.
        s1 = dv1; s2 = dv2;
        sav(0, 0); pairs(360, 1); trs(0, 0, 1);
        idle(8);
        check_eq("dec_cnt", 32'(dv1 - s1), 32'd640);
        check_eq("maxx_cnt", 32'(dv2 - s2), 32'd15);
        sb_check("dec");

        // Bad XY in BLANK leaves state and flags alone.
        se = nerr;
        put(8'hFF); put(8'h00); put(8'h00); put(8'h70);
        idle(2);
        check_eq("blank_bad_err", 32'(nerr - se), 32'd1);
        check_eq("blank_bad_flags", 32'({fld1, vb1}), 32'd0);
        s1 = dv1;
        sav(0, 0); pairs(6, 1); trs(0, 0, 1);
        idle(8);
        check_eq("blank_line_cnt", 32'(dv1 - s1), 32'd11);
        sb_check("blank");

        // SAV with V=1 keeps BLANK.
        sav(0, 1); pairs(3, 0); trs(0, 1, 1);
        idle(6);
        check_eq("vblank_flag", 32'(vb1), 32'd1);
        sb_check("vsav");

        // SAV inside ACTIVE: error and x restart.
        se = nerr;
        sav(0, 0); pairs(3, 1); sav(0, 0); pairs(5, 1); trs(0, 0, 1);
        idle(8);
        check_eq("sav_act_err", 32'(nerr - se), 32'd1);
        sb_check("restart");

        // EAV after Cb, Y0 of a pair: only the two complete pairs come out.
        s1 = dv1;
        sav(0, 0); pairs(2, 1); put(8'h12); put(8'h24); trs(0, 0, 1);
        idle(8);
        check_eq("trunc_cnt", 32'(dv1 - s1), 32'd4);
        sb_check("trunc");

        // One-cycle reset mid-line.
        chk_en = 1'b0;
        sav(0, 0); pairs(10, 0);
        rst_n = 1'b0;
        put(8'h10);
        check_eq("midrst_out", 32'({dval1, x1, y1, ycc1, fld1, vb1, sof1, err1}), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        s1 = dv1;
        pairs(5, 0); sav(0, 0); pairs(3, 0); trs(0, 0, 1);
        idle(4);
        check_eq("midrst_quiet", 32'(dv1 - s1), 32'd0);
        sav(0, 0); pairs(4, 1); trs(0, 0, 1);
        idle(8);
        check_eq("midrst_line", 32'(dv1 - s1), 32'd8);
        sb_check("midrst");

        // Field tracking: 253 EAVs with F=0, then F=1.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 253; i++) trs(0, 0, 1);
        idle(2);
        check_eq("fld_y", 32'(y1), 32'd253);
        check_eq("fld_y_sat", 32'(y2), 32'd7);
        check_eq("fld_f0", 32'(fld1), 32'd0);
        ss = nsof;
        trs(1, 0, 1);
        idle(4);
        check_eq("fld_sof", 32'(nsof - ss), 32'd1);
        check_eq("fld_f1", 32'(fld1), 32'd1);
        check_eq("fld_y0", 32'(y1), 32'd0);
        check_eq("fld_y0_small", 32'(y2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tv656_decim_decoder.md
TV656_DECIM_DECODER -- requirements
Module: tv656_decim_decoder

Interface
REQ-001 Parameter DATA_W, default 8, sets the ITU-R 656 word width; legal values are 8 and 10.
REQ-002 Parameter SKIP_N, default 9, sets the decimation ratio: one input pixel in every SKIP_N is dropped; 0 disables dropping; legal values are 0 and 2..15.
REQ-003 Parameter MAX_X, default 720, sets the maximum number of input pixels accepted per line.
REQ-004 Parameter Y_W, default 10, sets the width of the line counter.
REQ-005 Port iCLK, input, 1 bit: the single clock, which is the TV decoder pixel-word clock; every word on iTD_DATA is valid on every edge.
REQ-006 Port iRST_N, input, 1 bit: synchronous, active-low reset.
REQ-007 Port iTD_DATA, input, DATA_W bits: the ITU-R 656 word stream (Cb Y Cr Y ..., with embedded EAV/SAV codes).
REQ-008 Port oYCbCr, output, 2*DATA_W bits: {Y, C}, with Y in the upper half.
REQ-009 Port oDVAL, output, 1 bit: oYCbCr, oTV_X and oTV_Y are valid.
REQ-010 Port oTV_X, output, 10 bits: output pixel index within the line, after decimation.
REQ-011 Port oTV_Y, output, Y_W bits: line index within the current field.
REQ-012 Ports oFIELD and oVBLANK, outputs, 1 bit each: the F and V bits of the last accepted timing reference.
REQ-013 Ports oSOF and oERR, outputs, 1 bit each: single-cycle pulses for start of field and timing-reference error.

Function
REQ-014 The block SHALL detect a preamble as three consecutive words: all-ones, then zero, then zero; the fourth word is XY.
REQ-015 XY bit mapping SHALL be: bit DATA_W-1 = 1, F = bit DATA_W-2, V = bit DATA_W-3, H = bit DATA_W-4 (H=1 means EAV, H=0 means SAV); protection bits SHALL be ignored.
REQ-016 A preamble whose XY has bit DATA_W-1 = 0 SHALL pulse oERR for one cycle and SHALL be ignored otherwise.
REQ-017 The pixel path SHALL consume iTD_DATA through a 3-word delay line, so preamble words never reach the pixel path as pixels.
REQ-018 The FSM states SHALL be HUNT, BLANK and ACTIVE; reset enters HUNT.
  - HUNT -> BLANK on any valid EAV.
  - BLANK -> ACTIVE on a SAV with V=0.
  - ACTIVE -> BLANK on an EAV, or when the MAX_X input pixel count is reached.
  - An SAV received while in ACTIVE SHALL pulse oERR and restart the line (the x counters clear).
  - An SAV with V=1 SHALL keep the FSM in BLANK.
REQ-019 In ACTIVE, words SHALL be grouped as Cb, Y0, Cr, Y1; input pixel p = 2m takes Y0 and p = 2m+1 takes Y1 of pair m.
REQ-020 Input pixel p SHALL be dropped when SKIP_N != 0 and p mod SKIP_N == SKIP_N-1; the modulo counter SHALL be implemented without a divider and SHALL clear at SAV.
REQ-021 For each kept pixel, C SHALL be Cb of its own pair when oTV_X is even, and Cr of its own pair when oTV_X is odd, so chroma alternation is preserved across drops.
REQ-022 Latency from a word on iTD_DATA to oDVAL SHALL be 5 cycles for Y0 and 4 cycles for Y1; output pixels are emitted Y0 then Y1 on consecutive cycles.
REQ-023 oTV_X SHALL start at 0 for the first kept pixel after SAV, increment by 1 per oDVAL, and clear at SAV.
REQ-024 oTV_Y SHALL increment on each EAV, saturate at 2^Y_W-1, and clear when F changes.
REQ-025 oSOF SHALL pulse on the cycle F changes; oFIELD SHALL update on the same cycle.
REQ-026 A pair truncated by an EAV or by the MAX_X limit SHALL be discarded, and no oDVAL is produced for it.
REQ-027 oDVAL SHALL be 0 in HUNT and BLANK, except for the final in-flight pixel of a completed pair.

Reset
REQ-028 While iRST_N=0 at a clock edge, the block SHALL clear all outputs, counters, the delay line and the chroma registers, and SHALL enter HUNT; this applies equally to a reset asserted mid-line.
REQ-029 After reset the block SHALL emit no oDVAL until it has seen an EAV followed by a SAV with V=0.

Verification
REQ-030 Reset mid-line: drive an active line, assert iRST_N=0 for 1 cycle mid-line -> all outputs 0, oDVAL stays 0 until EAV then SAV(V=0).
REQ-031 Decimation: SKIP_N=9, an NTSC active line of 720 pixels -> exactly 640 oDVAL; oTV_X runs 0..639; input pixels 8, 17, 26, ... are absent.
REQ-032 Chroma phase: pair m has Cb=0x10+m and Cr=0x80+m, SKIP_N=9 -> every even oTV_X carries a Cb value and every odd oTV_X carries a Cr value.
REQ-033 Field tracking: 253 EAVs with F=0, then XY with F=1 -> oSOF pulses once, oFIELD=1, oTV_Y returns to 0.
REQ-034 Error handling: preamble followed by XY=0x70 -> oERR pulses once and the FSM state is unchanged; a SAV in ACTIVE -> oERR pulses and oTV_X restarts at 0.
REQ-035 Truncation: EAV arrives after Cb and Y0 of a pair -> no oDVAL for that Y0; MAX_X=16 -> exactly 16 minus dropped pixels emitted.
